// File: rtl/filter_frame_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | filter_frame_bridge: collects 256-sample frames for a block filter and     |
// | streams its result back out. Option macro: BRIDGE_OVERLAP_EN.   Rev 1.0    |
// +----------------------------------------------------------------------------+
module filter_frame_bridge #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] frame_sig [0:255],
  output logic       start_flg,
  input  logic       rdy_flg,
  input  logic [7:0] filt_sig [0:255],
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       err_flg
);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam int         CW      = $clog2(WAIT_TIMEOUT) + 1;

  logic [1:0]    state_q, state_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          full_q, full_d;
  logic [7:0]    frame_q [0:255];
  logic          can_accept, accept, fill_last, beat, last_beat;

`ifdef BRIDGE_OVERLAP_EN
  // Next frame may load while the current one drains, until it is complete.
  assign can_accept = ((state_q == S_FILL) || (state_q == S_DRAIN)) && !full_q;
`else
  assign can_accept = (state_q == S_FILL);
`endif

  assign in_ready  = can_accept & ~rst;
  assign accept    = in_valid & in_ready;
  assign fill_last = accept && (wr_idx_q == 8'd255);
  assign out_valid = (state_q == S_DRAIN);
  assign beat      = out_valid & out_ready;
  assign last_beat = beat && (rd_idx_q == 8'd255);
  assign out_data  = out_valid ? filt_sig[rd_idx_q] : 8'h00;
  assign out_last  = out_valid && (rd_idx_q == 8'd255);
  assign start_flg = start_q;
  assign err_flg   = err_q;
  assign frame_sig = frame_q;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    full_d   = full_q;
    if (accept) wr_idx_d = wr_idx_q + 8'd1;
    case (state_q)
      S_FILL: begin
        if (fill_last) state_d = S_START;
      end
      S_START: begin
        state_d = S_WAIT;
        wcnt_d  = '0;
      end
      S_WAIT: begin
        if (rdy_flg) begin
          state_d  = S_DRAIN;
          rd_idx_d = 8'd0;
        end else if (wcnt_q == CW'(WAIT_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FILL;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: begin
        if (fill_last) full_d = 1'b1;
        if (beat) rd_idx_d = rd_idx_q + 8'd1;
        if (last_beat) begin
          state_d = (full_q || fill_last) ? S_START : S_FILL;
          full_d  = 1'b0;
        end
      end
    endcase
    start_d = (state_d == S_START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FILL;
      wr_idx_q <= 8'd0;
      rd_idx_q <= 8'd0;
      wcnt_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      for (int i = 0; i < 256; i++) frame_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      wcnt_q   <= wcnt_d;
      start_q  <= start_d;
      err_q    <= err_d;
      full_q   <= full_d;
      if (accept) frame_q[wr_idx_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: doc/filter_frame_bridge.md
FILTER_FRAME_BRIDGE -- requirements
Module: filter_frame_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous active-high reset (one clock, async active-high reset, fixed).
REQ-002 SHALL have ports: in_valid  in  1  sample offered; in_data  in  8  unsigned sample; in_ready  out  1  sample accepted when in_valid&in_ready at a rising edge.
REQ-003 SHALL have ports: frame_sig  out  8x[0:255]  frame to filter inputSig; start_flg  out  1  filter start pulse; rdy_flg  in  1  filter done (sticky, held high by filter); filt_sig  in  8x[0:255]  filter outputSig.
REQ-004 SHALL have ports: out_valid  out  1; out_data  out  8  filtered sample; out_last  out  1  high with index 255; out_ready  in  1; err_flg  out  1  sticky timeout error.
REQ-005 SHALL have parameter: WAIT_TIMEOUT, default 16, maximum WAIT cycles before error.

Function
REQ-006 SHALL implement states FILL, START, WAIT, DRAIN; reset state FILL.
REQ-007 FILL: in_ready=1; each accepted sample written to frame_sig[wr_idx], wr_idx+1; on acceptance at wr_idx=255 -> START, wr_idx wraps to 0.
REQ-008 START: exactly one cycle, start_flg=1 (registered output, 0 in every other state), frame_sig held stable; -> WAIT.
REQ-009 WAIT: rdy_flg sampled only in WAIT, never in START; rdy_flg=1 -> DRAIN with rd_idx=0; sticky rdy from a prior frame valid because WAIT begins after filter sampled start.
REQ-010 WAIT: cycle counter; WAIT_TIMEOUT consecutive WAIT cycles with rdy_flg=0 -> err_flg=1 (sticky until rst), -> FILL, frame discarded.
REQ-011 DRAIN: out_valid=1, out_data=filt_sig[rd_idx], out_last=(rd_idx==255); rd_idx+1 on out_valid&out_ready.
REQ-012 out_data/out_last SHALL stay stable while out_valid&!out_ready; out_valid never drops mid-frame.
REQ-013 Beat at rd_idx=255 accepted -> FILL (or START per REQ-018); rd_idx wraps to 0.
REQ-014 Latency: sample 255 accepted at edge E -> start_flg high in cycle after E; first out_valid after third rising edge from E (zero bubbles with rdy immediate).
REQ-015 All 256 outputs SHALL be streamed, including filter's zero warm-up indices 0..49; no arithmetic on samples.
REQ-016 frame_sig writes and filter capture at same edge: filter SHALL see pre-edge value (registered writes only).

Reset
REQ-017 rst asserted, any state, mid-fill or mid-drain: state FILL, wr_idx=rd_idx=0, wait counter 0, frame_sig all 0x00, start_flg=0, out_valid=0, out_last=0, out_data=0x00, in_ready=0 while rst high then 1, err_flg=0; partial frames discarded.

Configuration
REQ-018 Macro BRIDGE_OVERLAP_EN defined: in_ready=1 in FILL and DRAIN (0 in START/WAIT) until next frame holds 256 samples; drain end with full next frame -> START directly, else FILL continuing at wr_idx; last fill beat and last drain beat on same edge -> START.
REQ-019 BRIDGE_OVERLAP_EN undefined: in_ready=1 only in FILL; each frame fully drained before next sample accepted.

Verification
REQ-020 Ramp: feed 0..255 continuously, rdy immediate, out_ready=1 -> start_flg one cycle; out indices 0..49 = 0, index 50 = 25, index 255 = 230; out_last only on 256th beat.
REQ-021 Backpressure: constant 0x80 frame, out_ready toggling 1/0 -> 256 beats, indices 50..255 = 0x80, data stable during stalls, no lost/duplicate beats.
REQ-022 Timeout: rdy_flg forced 0 after start -> err_flg=1 after 16 WAIT cycles, state FILL, out_valid never asserted.
REQ-023 Reset mid-drain: rst pulse at rd_idx=100 -> out_valid=0 immediately, frame_sig all 0, next full frame processed normally from index 0.
REQ-024 Overlap (BRIDGE_OVERLAP_EN): two back-to-back frames 0x10 then 0x20, in_valid=1 always -> second frame accepted during drain, second start_flg one cycle after first drain's out_last beat, outputs 0x10 then 0x20 at indices 50..255.
REQ-025 Sticky rdy: second frame after first with rdy_flg never deasserted -> second drain reflects second frame data, not first.
